// File: rtl/signed_sequential_divider_pkg.sv
// Shared definitions for the signed sequential divider: FSM states,
// default operand width and step-counter sizing.
package signed_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

    // Counter must hold 0..WIDTH.
    function automatic int unsigned step_cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/signed_sequential_divider_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes:
// shift in the next dividend bit, trial-subtract the divisor, restore on borrow.
module div_step
    import signed_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] dvs_mag,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] diff;

    always_comb begin
        trial   = {rem_in, dvd_bit};
        diff    = trial - {2'b00, dvs_mag};
        // Top bit of diff is the borrow: set means the trial went negative.
        q_bit   = ~diff[WIDTH+1];
        rem_out = (WIDTH+1)'(q_bit ? diff : trial);
    end

endmodule

// File: rtl/signed_sequential_divider.sv
// Iterative signed divider, one restoring step per clock with start/busy/done
// handshake. Optional macro DIV_ZERO_FAST_EN short-circuits a zero divisor.
module signed_sequential_divider
    import signed_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CW = step_cnt_width(WIDTH);

    div_state_t state, state_nxt;

    logic [WIDTH-1:0] dvd_q;      // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   prem;
    logic [CW-1:0]    step_cnt;
    logic             sign_a;
    logic             sign_b;
    logic             ovf_pend;
    logic             dz_pend;

    logic             accept;
    logic             last_step;
    logic             divisor_zero;
    logic             ovf_in;
    logic [WIDTH:0]   step_rem;
    logic             step_q;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    assign accept       = start && ((state == IDLE) || (state == DONE));
    assign last_step    = (step_cnt == CW'(WIDTH - 1));
    assign divisor_zero = (divisor == '0);
    assign ovf_in       = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);

    assign busy = (state == RUN) || (state == FIX);
    assign done = (state == DONE);

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (prem),
        .dvd_bit (dvd_q[WIDTH-1]),
        .dvs_mag (dvs_mag),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
`ifdef DIV_ZERO_FAST_EN
                    state_nxt = divisor_zero ? DONE : RUN;
`else
                    state_nxt = RUN;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN:     state_nxt = last_step ? FIX : RUN;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_q       <= '0;
            dvs_mag     <= '0;
            prem        <= '0;
            step_cnt    <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            ovf_pend    <= 1'b0;
            dz_pend     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            dvd_q    <= magnitude(dividend);
            dvs_mag  <= magnitude(divisor);
            sign_a   <= dividend[WIDTH-1];
            sign_b   <= divisor[WIDTH-1];
            prem     <= '0;
            step_cnt <= '0;
            ovf_pend <= ovf_in;
            dz_pend  <= divisor_zero;
`ifdef DIV_ZERO_FAST_EN
            // Zero divisor skips RUN/FIX, so results are published here.
            if (divisor_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
                overflow    <= 1'b0;
            end
`endif
        end else if (state == RUN) begin
            prem     <= step_rem;
            dvd_q    <= {dvd_q[WIDTH-2:0], step_q};
            step_cnt <= step_cnt + CW'(1);
        end else if (state == FIX) begin
            quotient    <= (sign_a ^ sign_b) ? WIDTH'(-dvd_q) : dvd_q;
            remainder   <= sign_a ? WIDTH'(-prem[WIDTH-1:0]) : prem[WIDTH-1:0];
            div_by_zero <= dz_pend;
            overflow    <= ovf_pend;
        end
    end

endmodule

// File: tb/tb_signed_sequential_divider.sv
// Directed self-checking bench for signed_sequential_divider (WIDTH=8);
// expectations follow DIV_ZERO_FAST_EN when it is defined.
module tb_signed_sequential_divider;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    signed_sequential_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Launch one operation; optionally re-pulse start with other operands
    // glitch_at edges in. Returns edges from start until done (0 on timeout).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int glitch_at, output int lat);
        lat = 0;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (n == glitch_at) begin
                dividend = 8'd50;
                divisor  = 8'd3;
                start    = 1'b1;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        if (lat == 0) check("timeout", 32'd0, 32'd1);
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat,
                                input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dz, input logic ov);
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".q"}, quotient, q);
        check({tag, ".r"}, remainder, r);
        check({tag, ".dz"}, div_by_zero, dz);
        check({tag, ".ovf"}, overflow, ov);
        check({tag, ".busy"}, busy, 1'b0);
    endtask

    initial begin
        int lat;
        int seen_done;

        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check("rst.q", quotient, 0);
        check("rst.r", remainder, 0);
        check("rst.dz", div_by_zero, 0);
        check("rst.ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b1;

        run_op(8'd100, 8'd7, 0, lat);
        check_result("100/7", lat, 10, 8'd14, 8'd2, 0, 0);

        // Issued while the previous result is in DONE.
        run_op(8'(-100), 8'd7, 0, lat);
        check_result("-100/7", lat, 10, 8'hF2, 8'hFE, 0, 0);
        @(posedge clk);
        #1;
        check("pulse.done", done, 0);
        check("hold.q", quotient, 8'hF2);
        check("hold.r", remainder, 8'hFE);

        run_op(8'd100, 8'(-7), 0, lat);
        check_result("100/-7", lat, 10, 8'hF2, 8'h02, 0, 0);
        run_op(8'(-100), 8'(-7), 0, lat);
        check_result("-100/-7", lat, 10, 8'h0E, 8'hFE, 0, 0);

        run_op(8'h80, 8'hFF, 0, lat);
        check_result("-128/-1", lat, 10, 8'h80, 8'h00, 0, 1);
        run_op(8'h80, 8'h01, 0, lat);
        check_result("-128/1", lat, 10, 8'h80, 8'h00, 0, 0);

`ifdef DIV_ZERO_FAST_EN
        run_op(8'd37, 8'd0, 0, lat);
        check_result("37/0", lat, 1, 8'hFF, 8'd37, 1, 0);
        run_op(8'(-37), 8'd0, 0, lat);
        check_result("-37/0", lat, 1, 8'hFF, 8'hDB, 1, 0);
`else
        run_op(8'd37, 8'd0, 0, lat);
        check_result("37/0", lat, 10, 8'hFF, 8'd37, 1, 0);
        run_op(8'(-37), 8'd0, 0, lat);
        check_result("-37/0", lat, 10, 8'h01, 8'hDB, 1, 0);
`endif

        run_op(8'd100, 8'd7, 4, lat);
        check_result("ignore_start", lat, 10, 8'd14, 8'd2, 0, 0);

        // Reset asserted mid-operation.
        @(negedge clk);
        dividend = 8'd90;
        divisor  = 8'd4;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort.busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        check("abort.q", quotient, 0);
        check("abort.r", remainder, 0);
        check("abort.dz", div_by_zero, 0);
        check("abort.ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b1;
        seen_done = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("abort.no_done", seen_done, 0);

        run_op(8'd50, 8'd3, 0, lat);
        check_result("after_rst", lat, 10, 8'd16, 8'd2, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
